// File: rtl/m_006_down_timer.sv
// Loadable down-counting timer: counts a captured value to zero, pulses tc_o, then
// stops in DONE (one-shot) or reloads the captured period (periodic).
module m_006_down_timer #(
  parameter int unsigned Width = 4
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic             reload_i,
  input  logic [Width-1:0] load_val_i,
  output logic [Width-1:0] cnt_o,
  output logic             busy_o,
  output logic             tc_o,
  output logic             done_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             r_state;
  logic [Width-1:0]   r_cnt;
  logic [Width-1:0]   r_period;
  logic               r_reload;
  logic               r_busy;
  logic               r_tc;
  logic               r_done;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state  <= StIdle;
      r_cnt    <= '0;
      r_period <= '0;
      r_reload <= 1'b0;
      r_busy   <= 1'b0;
      r_tc     <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_tc <= 1'b0;
      unique case (r_state)
        StIdle, StDone: begin
          // stop_i outranks start_i; cnt_o is left as-is when going idle
          if (stop_i) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end else if (start_i) begin
            r_state  <= StRun;
            r_cnt    <= load_val_i;
            r_period <= load_val_i;
            r_reload <= reload_i;
            r_busy   <= 1'b1;
            r_done   <= 1'b0;
          end
        end
        StRun: begin
          // Zero test comes before decrement, so the count never wraps
          if (stop_i) begin
            r_state <= StIdle;
            r_busy  <= 1'b0;
          end else if (r_cnt == '0) begin
            r_tc <= 1'b1;
            if (r_reload) begin
              r_cnt <= r_period;
            end else begin
              r_state <= StDone;
              r_busy  <= 1'b0;
              r_done  <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state <= StIdle;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign cnt_o  = r_cnt;
  assign busy_o = r_busy;
  assign tc_o   = r_tc;
  assign done_o = r_done;

endmodule

// File: tb/tb_m_006_down_timer.sv
// Directed vector bench for m_006_down_timer: a table of per-cycle inputs and
// expected outputs, plus hand-written reset sequences.
module tb_m_006_down_timer;

  logic       clk_i = 1'b0;
  logic       n_rst_i;
  logic       start_i, stop_i, reload_i;
  logic [3:0] load_val_i;
  logic [3:0] cnt_o;
  logic       busy_o, tc_o, done_o;

  int n_tests = 0;
  int n_fail  = 0;

  m_006_down_timer #(.Width(4)) dut (
    .clk_i      (clk_i),
    .n_rst_i    (n_rst_i),
    .start_i    (start_i),
    .stop_i     (stop_i),
    .reload_i   (reload_i),
    .load_val_i (load_val_i),
    .cnt_o      (cnt_o),
    .busy_o     (busy_o),
    .tc_o       (tc_o),
    .done_o     (done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    bit       start;
    bit       stop;
    bit       reload;
    bit [3:0] load;
    bit [3:0] cnt;
    bit       busy;
    bit       tc;
    bit       done;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input bit st, input bit sp, input bit rl, input int ld,
                     input int c, input bit b, input bit t, input bit d);
    vec_t v;
    v.start = st; v.stop = sp; v.reload = rl; v.load = 4'(ld);
    v.cnt = 4'(c); v.busy = b; v.tc = t; v.done = d;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input int c, input bit b, input bit t,
                       input bit d);
    n_tests += 4;
    if (cnt_o !== 4'(c)) begin
      n_fail++;
      $display("FAIL %s cnt_o: got %0d want %0d", name, cnt_o, c);
    end
    if (busy_o !== b) begin
      n_fail++;
      $display("FAIL %s busy_o: got %b want %b", name, busy_o, b);
    end
    if (tc_o !== t) begin
      n_fail++;
      $display("FAIL %s tc_o: got %b want %b", name, tc_o, t);
    end
    if (done_o !== d) begin
      n_fail++;
      $display("FAIL %s done_o: got %b want %b", name, done_o, d);
    end
  endtask

  task automatic drive(input bit st, input bit sp, input bit rl, input int ld);
    start_i = st; stop_i = sp; reload_i = rl; load_val_i = 4'(ld);
  endtask

  initial begin
    n_rst_i = 1'b0;
    drive(1, 0, 0, 5);

    // Reset held with clock running and start asserted
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i); #1;
      check("reset_hold", 0, 0, 0, 0);
    end
    #3 n_rst_i = 1'b1;
    drive(0, 0, 0, 0);

    // One-shot N=5
    add(1, 0, 0, 5, 5, 1, 0, 0);
    for (int c = 4; c >= 0; c--) add(0, 0, 0, 9, c, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);
    // stop+start together in DONE -> IDLE
    add(1, 1, 1, 7, 0, 0, 0, 0);
    add(0, 0, 0, 7, 0, 0, 0, 0);

    // Periodic N=3, start mid-run ignored, later load_val changes ignored
    add(1, 0, 1, 3, 3, 1, 0, 0);
    for (int p = 0; p < 5; p++) begin
      add(p == 1, 0, 0, (p == 1) ? 9 : 12, 2, 1, 0, 0);
      add(0, 0, 0, 12, 1, 1, 0, 0);
      add(0, 0, 0, 12, 0, 1, 0, 0);
      add(0, 0, 0, 12, 3, 1, 1, 0);
    end
    add(0, 1, 0, 12, 3, 0, 0, 0);

    // Periodic N=10, stop at cnt=4
    add(1, 0, 1, 10, 10, 1, 0, 0);
    for (int c = 9; c >= 4; c--) add(0, 0, 0, 0, c, 1, 0, 0);
    add(0, 1, 0, 0, 4, 0, 0, 0);
    add(0, 0, 0, 0, 4, 0, 0, 0);

    // Stop coinciding with zero count: no tc
    add(1, 0, 1, 1, 1, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1, 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 0, 0, 0);

    // One-shot N=15, no wrap past zero
    add(1, 0, 0, 15, 15, 1, 0, 0);
    for (int c = 14; c >= 0; c--) add(0, 0, 0, 3, c, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);

    // One-shot N=0 started from DONE
    add(1, 0, 0, 0, 0, 1, 0, 0);
    add(0, 0, 0, 0, 0, 0, 1, 1);
    add(0, 0, 0, 0, 0, 0, 0, 1);

    // Periodic N=0 -> tc continuously high
    add(1, 0, 1, 0, 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) add(0, 0, 0, 5, 0, 1, 1, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);

    foreach (vecs[i]) begin
      drive(vecs[i].start, vecs[i].stop, vecs[i].reload, int'(vecs[i].load));
      @(posedge clk_i); #1;
      check($sformatf("vec%0d", i), int'(vecs[i].cnt), vecs[i].busy, vecs[i].tc,
            vecs[i].done);
    end

    // Async reset mid-run: N=9 one-shot, drop reset between edges at cnt=6
    drive(1, 0, 0, 9);
    @(posedge clk_i); #1;
    check("ar_start", 9, 1, 0, 0);
    drive(0, 0, 0, 9);
    for (int c = 8; c >= 6; c--) begin
      @(posedge clk_i); #1;
      check("ar_count", c, 1, 0, 0);
    end
    #2 n_rst_i = 1'b0;
    #1 check("ar_immediate", 0, 0, 0, 0);
    @(posedge clk_i); #1;
    check("ar_held", 0, 0, 0, 0);
    n_rst_i = 1'b1;
    drive(1, 0, 0, 2);
    @(posedge clk_i); #1;
    check("ar_restart", 2, 1, 0, 0);
    drive(0, 0, 0, 0);
    @(posedge clk_i); #1;
    check("ar_c1", 1, 1, 0, 0);
    @(posedge clk_i); #1;
    check("ar_c0", 0, 1, 0, 0);
    @(posedge clk_i); #1;
    check("ar_tc", 0, 0, 1, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/m_006_down_timer.md
# m_006_down_timer

Loadable, parameterised down-counting timer: the complement of the free-running up counter. It counts a loaded value down to zero, emits a terminal-count pulse, and either stops (one-shot) or reloads (periodic). Used as a delay/timeout generator and tick divider in the same single-clock designs as the up counter.

## Interface
- width, 4, counter and load-value width in bits (≥1)
- clk_i  input  1  clock, all state updates on rising edge
- n_rst_i  input  1  reset, asynchronous, active-low
- start_i  input  1  start request; samples load_val_i and reload_i
- stop_i  input  1  abort request; returns block to IDLE
- reload_i  input  1  mode at start: 1 = periodic auto-reload, 0 = one-shot
- load_val_i  input  width  start value N
- cnt_o  output  width  current count
- busy_o  output  1  high while in RUN
- tc_o  output  1  terminal-count pulse, one cycle wide
- done_o  output  1  one-shot completion flag, level, held in DONE

## Operation
- FSM states: IDLE, RUN, DONE. Internal registers: state, reload_q (mode), period_q (width bits, captured N).
- Reset (n_rst_i low, any time, clock-independent): state=IDLE, cnt_o=0, busy_o=0, tc_o=0, done_o=0, reload_q=0, period_q=0.
- IDLE: start_i=1 -> cnt_o<=load_val_i, period_q<=load_val_i, reload_q<=reload_i, state RUN. Otherwise all held; cnt_o keeps last value.
- RUN, cnt_o≠0: cnt_o<=cnt_o-1.
- RUN, cnt_o==0: tc_o<=1 for one cycle; if reload_q: cnt_o<=period_q, stay RUN; else state DONE, done_o<=1, cnt_o stays 0.
- DONE: done_o held 1, busy_o 0, cnt_o 0. start_i -> same as IDLE start, done_o<=0. stop_i -> IDLE, done_o<=0.
- stop_i in RUN -> IDLE next edge; cnt_o frozen at current value; no tc_o, no done_o.
- Priority: stop_i over start_i in every state; stop_i over terminal event in RUN (zero count + stop -> IDLE, no tc_o).
- start_i while in RUN ignored (no restart, mode and period unchanged).
- Decrement never wraps: zero check precedes decrement; cnt_o never goes from 0 to all-ones.
- load_val_i changes after start have no effect until next start.
- busy_o = (state==RUN), registered alongside state.

## Timing
- Start sampled at edge k: cnt_o=N, busy_o=1 after edge k.
- cnt_o reaches 0 after edge k+N; tc_o=1 during cycle after edge k+N+1 (one clock only).
- One-shot: done_o=1 and busy_o=0 after edge k+N+1; total N+1 cycles start-to-tc.
- Periodic: tc_o pulses every N+1 cycles; cnt_o=N in cycle following each tc edge.
- N=0: tc_o after edge k+1; periodic N=0 gives tc_o high every cycle (continuous).
- Stop: effect after next edge; tc_o, done_o low from that edge.
- Reset assertion clears outputs immediately (not at an edge); first start honoured at first rising edge with n_rst_i high.

## Test plan
- Reset: hold n_rst_i=0 with clock running and start_i=1 -> cnt_o=0, busy_o=0, tc_o=0, done_o=0 throughout.
- One-shot: width=4, N=5, reload_i=0, start pulse -> cnt_o 5,4,3,2,1,0; tc_o single pulse 6 cycles after start edge; done_o=1, busy_o=0 held until next start.
- Periodic: N=3, reload_i=1 -> tc_o pulses every 4 cycles for ≥5 periods; cnt_o sequence 3,2,1,0,3,...; done_o stays 0; start_i mid-run ignored.
- Stop: N=10 periodic, stop_i when cnt_o=4 -> IDLE, cnt_o holds 4, no tc_o; stop_i and start_i together in DONE -> IDLE, done_o cleared.
- Boundaries: N=15 one-shot -> tc_o 16 cycles after start, no wrap past 0; N=0 one-shot -> tc_o/done_o after 1 cycle; N=0 periodic -> tc_o continuously high.
- Async reset mid-run: N=9, drop n_rst_i between clock edges at cnt_o=6 -> all outputs 0 immediately, state IDLE; release, start N=2 -> normal 3-cycle one-shot.
